// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Register bank written by N_REQ requesters through a round-robin arbiter,
//   with a sequenced bank-clear operation and a registered read port.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   req_valid  : per-requester write request
//   req_addr   : per-requester target register (ADDR_W bits per slice)
//   req_data   : per-requester write data (DATA_W bits per slice)
//   req_ready  : combinational one-hot accept (zero when nothing accepted)
//   clr_start  : single-cycle request to zero the whole bank
//   clr_busy   : high while the clear sequence runs
//   clr_done   : one-cycle pulse on the first idle cycle after a clear
//   rd_addr    : read address
//   rd_data    : registered read data (1-cycle latency)
//   gnt_valid  : registered, a write was accepted in the previous cycle
//   gnt_id     : registered, index of that requester (held otherwise)
module reg_bank_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned N_REGS = 8,
  parameter int unsigned ADDR_W = 3,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     gnt_valid,
  output logic [ID_W-1:0]          gnt_id
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   bank [N_REGS];

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     cand;
  logic                accept;
  logic                clr_last;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ID_W-1:0]     rr_next;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = ID_W'((32'(rr_ptr) + off) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // rst gates acceptance so req_ready reads zero while held in reset.
  assign accept   = rst && (state == IDLE) && !clr_start && found;
  assign clr_last = (clr_idx == ADDR_W'(N_REGS - 1));
  assign clr_busy = (state == CLEAR);
  assign wr_addr  = req_addr[32'(winner) * ADDR_W +: ADDR_W];
  assign wr_data  = req_data[32'(winner) * DATA_W +: DATA_W];
  assign rr_next  = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_start) state_next = CLEAR;
      CLEAR:   if (clr_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        bank[i] <= '0;
      end
      rr_ptr    <= '0;
      clr_idx   <= '0;
      clr_done  <= 1'b0;
      rd_data   <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      // Read samples the pre-write contents, so a same-cycle write to
      // rd_addr is seen one cycle later.
      rd_data   <= bank[rd_addr];
      gnt_valid <= accept;
      clr_done  <= (state == CLEAR) && clr_last;
      if (accept) begin
        bank[wr_addr] <= wr_data;
        rr_ptr        <= rr_next;
        gnt_id        <= winner;
      end
      if (state == CLEAR) begin
        bank[clr_idx] <= '0;
        // N_REGS is a power of two, so the index wraps back to 0 at the end.
        clr_idx       <= clr_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Self-checking bench for reg_bank_arbiter. A cycle-level reference model
//   predicts combinational outputs directly and pushes predicted registered
//   outputs onto a scoreboard queue, which is popped after the clock edge.
module tb_reg_bank_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned N_REGS = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned ID_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [N_REQ*DATA_W-1:0] req_data  = '0;
  logic [N_REQ-1:0]        req_ready;
  logic                    clr_start = 1'b0;
  logic                    clr_busy;
  logic                    clr_done;
  logic [ADDR_W-1:0]       rd_addr = '0;
  logic [DATA_W-1:0]       rd_data;
  logic                    gnt_valid;
  logic [ID_W-1:0]         gnt_id;

  reg_bank_arbiter #(
    .DATA_W (DATA_W),
    .N_REQ  (N_REQ),
    .N_REGS (N_REGS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] rd;
    logic              gv;
    logic [ID_W-1:0]   gid;
    logic              cd;
  } sb_t;

  sb_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_bank [N_REGS];
  logic              m_clear;
  int unsigned       m_rr;
  int unsigned       m_idx;
  logic [ID_W-1:0]   m_gid;

  // Observations of the most recent cycle
  logic [N_REQ-1:0]  obs_ready;
  logic              obs_busy;
  logic              obs_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_REGS; i++) m_bank[i] = '0;
    m_clear = 1'b0;
    m_rr    = 0;
    m_idx   = 0;
    m_gid   = '0;
    sb.delete();
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next
  // falling edge after the registered outputs have been checked.
  task automatic cycle();
    sb_t               e;
    logic              found;
    int unsigned       w;
    logic              acc;
    logic [N_REQ-1:0]  exp_ready;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    #1;
    found = 1'b0;
    w     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      int unsigned i;
      i = (m_rr + off) % N_REQ;
      if (!found && req_valid[i]) begin
        found = 1'b1;
        w     = i;
      end
    end
    acc       = !m_clear && !clr_start && found;
    exp_ready = acc ? N_REQ'(1 << w) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("clr_busy", 64'(clr_busy), 64'(m_clear));
    obs_ready = req_ready;
    obs_busy  = clr_busy;
    wa = req_addr[w*ADDR_W +: ADDR_W];
    wd = req_data[w*DATA_W +: DATA_W];
    e.rd  = m_bank[rd_addr];
    e.gv  = acc;
    e.gid = acc ? ID_W'(w) : m_gid;
    e.cd  = m_clear && (m_idx == N_REGS - 1);
    sb.push_back(e);
    @(posedge clk);
    if (acc) begin
      m_bank[wa] = wd;
      m_rr       = (w + 1) % N_REQ;
      m_gid      = ID_W'(w);
    end
    if (m_clear) begin
      m_bank[m_idx] = '0;
      if (m_idx == N_REGS - 1) m_clear = 1'b0;
      m_idx = (m_idx + 1) % N_REGS;
    end else if (clr_start) begin
      m_clear = 1'b1;
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check("rd_data", 64'(rd_data), 64'(e.rd));
      check("gnt_valid", 64'(gnt_valid), 64'(e.gv));
      check("gnt_id", 64'(gnt_id), 64'(e.gid));
      check("clr_done", 64'(clr_done), 64'(e.cd));
    end
    obs_done = clr_done;
  endtask

  // Asserts reset mid-cycle, checks outputs immediately, releases at the
  // next falling edge.
  task automatic do_reset();
    req_valid = '1;
    rst = 1'b0;
    #1;
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_gnt_valid", 64'(gnt_valid), 64'(0));
    check("rst_gnt_id", 64'(gnt_id), 64'(0));
    check("rst_clr_done", 64'(clr_done), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_clr_busy", 64'(clr_busy), 64'(0));
    model_reset();
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [N_REQ-1:0] seq [5];
    int unsigned zeros, busy, done, n;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;

    repeat (2) @(negedge clk);
    do_reset();

    // Round-robin with all four requesting
    for (int i = 0; i < N_REQ; i++) set_req(i, ADDR_W'(4 + i), DATA_W'(32'h100 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_seq", 64'(obs_ready), 64'(seq[k]));
    end
    req_valid = '0;

    // Same-cycle write and read of one address returns the old value
    set_req(0, 3'd3, 32'h11);
    req_valid = 4'b0001;
    rd_addr   = 3'd3;
    cycle();
    check("rd_old", 64'(rd_data), 64'(0));
    req_valid = '0;
    cycle();
    check("rd_new", 64'(rd_data), 64'(32'h11));

    // Single requester 2 write, then read back
    set_req(2, 3'd5, 32'hDEADBEEF);
    req_valid = 4'b0100;
    cycle();
    check("gnt_id_2", 64'(gnt_id), 64'(2));
    req_valid = '0;
    rd_addr   = 3'd5;
    cycle();
    check("rd_deadbeef", 64'(rd_data), 64'(32'hDEADBEEF));

    // Fill the bank with nonzero data from requester 1
    for (int k = 0; k < N_REGS; k++) begin
      set_req(1, ADDR_W'(k), DATA_W'(32'hA0 + k));
      req_valid = 4'b0010;
      cycle();
    end
    req_valid = '0;

    // Clear with a competing request in the same cycle
    set_req(0, 3'd6, 32'h55);
    req_valid = 4'b0001;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    zeros = (obs_ready == 0) ? 1 : 0;
    busy  = obs_busy ? 1 : 0;
    done  = obs_done ? 1 : 0;
    n = 0;
    while (n < 20 && obs_ready == 0) begin
      cycle();
      if (obs_ready == 0) zeros++;
      if (obs_busy) busy++;
      if (obs_done) done++;
      n++;
    end
    check("clr_ready_zero_cycles", 64'(zeros), 64'(9));
    check("clr_busy_cycles", 64'(busy), 64'(8));
    check("clr_done_pulses", 64'(done), 64'(1));
    req_valid = '0;
    for (int k = 0; k < N_REGS; k++) begin
      rd_addr = ADDR_W'(k);
      cycle();
    end
    cycle();
    check("rd_after_clr", 64'(rd_data), 64'(0));

    // clr_start repeated during CLEAR is ignored
    clr_start = 1'b1;
    cycle();
    busy = 0;
    done = 0;
    for (int k = 1; k <= 12; k++) begin
      clr_start = (k == 3);
      cycle();
      if (obs_busy) busy++;
      if (obs_done) done++;
    end
    clr_start = 1'b0;
    check("restart_busy_cycles", 64'(busy), 64'(8));
    check("restart_done_pulses", 64'(done), 64'(1));

    // Reset asserted during CLEAR cycle 4 aborts the sequence
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (3) cycle();
    check("pre_abort_busy", 64'(clr_busy), 64'(1));
    do_reset();
    done = 0;
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (k == 0) check("post_abort_first_grant", 64'(obs_ready), 64'(4'b0001));
      if (obs_done) done++;
    end
    req_valid = '0;
    check("post_abort_no_done", 64'(done), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of each bank register and of every data port.
REQ-002 Parameter N_REQ, default 4, number of write requesters (>=2).
REQ-003 Parameter N_REGS, default 8, number of bank registers (power of two).
REQ-004 Parameter ADDR_W, default 3, equals log2(N_REGS).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low; the block is in reset while rst=0.
REQ-007 req_valid  input  N_REQ  bit i: requester i presents a write.
REQ-008 req_addr  input  N_REQ*ADDR_W  slice i: target register of requester i.
REQ-009 req_data  input  N_REQ*DATA_W  slice i: write data of requester i.
REQ-010 req_ready  output  N_REQ  one-hot or zero; bit i: requester i's write is accepted this cycle.
REQ-011 clr_start  input  1  single-cycle request to zero the whole bank.
REQ-012 clr_busy  output  1  high while the clear sequence runs.
REQ-013 clr_done  output  1  one-cycle pulse after the last register is cleared.
REQ-014 rd_addr  input  ADDR_W  read address.
REQ-015 rd_data  output  DATA_W  registered read data.
REQ-016 gnt_valid  output  1  registered; high the cycle after a write was accepted.
REQ-017 gnt_id  output  log2(N_REQ)  registered; index of the requester accepted in the previous cycle.

Function
REQ-018 Bank: N_REGS registers of DATA_W bits, each loaded only through this block.
REQ-019 FSM states IDLE and CLEAR; IDLE->CLEAR when clr_start=1 in IDLE; CLEAR->IDLE after writing index N_REGS-1.
REQ-020 IDLE arbitration: round-robin; winner = first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
REQ-021 req_ready is combinational: req_ready[winner]=1, all other bits 0; all 0 if no req_valid or state is CLEAR.
REQ-022 Accepted write: bank[req_addr slice winner] <= req_data slice winner at the same rising edge; throughput one write per cycle.
REQ-023 After an accepted write rr_ptr <= (winner+1) mod N_REQ; rr_ptr unchanged in cycles with no acceptance.
REQ-024 clr_start=1 in IDLE takes priority: no grant that cycle (req_ready all 0), state -> CLEAR.
REQ-025 CLEAR: clear index k starts at 0, bank[k] <= 0 each cycle, k increments; N_REGS cycles total.
REQ-026 clr_busy=1 in every CLEAR cycle, 0 in IDLE (combinational from state).
REQ-027 clr_done=1 for exactly one cycle, the first IDLE cycle following CLEAR (registered).
REQ-028 clr_start while in CLEAR is ignored; no restart, no extension.
REQ-029 rd_data <= bank[rd_addr] every cycle (1-cycle latency); same-cycle write/read to one address returns the old value.
REQ-030 gnt_valid/gnt_id updated every cycle from the current acceptance; gnt_id holds its last value when gnt_valid=0.
REQ-031 Requesters hold req_valid, addr and data until req_ready; the block never drops or duplicates an accepted write.

Reset
REQ-032 While rst=0: all bank registers 0, state IDLE, rr_ptr 0, clear index 0.
REQ-033 Reset outputs: rd_data 0, gnt_valid 0, gnt_id 0, clr_done 0; req_ready 0 and clr_busy 0.
REQ-034 Reset asserted mid-CLEAR aborts the sequence; clr_done is not pulsed afterwards.
REQ-035 First grant after reset release is evaluated from rr_ptr 0.

Verification
REQ-036 Reset release, req_valid=4'b1111, distinct addr/data -> req_ready sequence 0001,0010,0100,1000,0001; gnt_id 0,1,2,3,0 one cycle later.
REQ-037 Req 2 only, addr 5, data 0xDEADBEEF; next cycle rd_addr=5 -> rd_data=0xDEADBEEF one cycle later; gnt_valid=1, gnt_id=2.
REQ-038 Bank full of nonzero data, clr_start=1 with req_valid=4'b0001 same cycle -> req_ready 0 for 9 cycles (1 + 8 CLEAR), clr_busy high 8 cycles, clr_done pulse, then req 0 accepted; all reads return 0 except the new write.
REQ-039 clr_start pulsed again at CLEAR cycle 3 -> clr_busy still exactly 8 cycles, single clr_done.
REQ-040 rst=0 at CLEAR cycle 4 -> all outputs 0 immediately, no clr_done after release, next grant from requester 0.
REQ-041 Write addr 3 data 0x11 with rd_addr=3 same cycle -> rd_data shows old value 0, then 0x11 one cycle later.
